// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the dual-core data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  // Wide enough for MEM_LAT-1 over the legal latency range 1..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the core that did not win last time is chosen.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = CORE0;
    if (req0 && req1) begin
      gnt_id = (last == CORE0) ? CORE1 : CORE0;
    end else if (req1) begin
      gnt_id = CORE1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two cores, one fixed-latency access in flight.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic gnt_valid;
  logic gnt_id;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next-state and registered-output logic; memory operands double as the latched request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    we_d        = we_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d     = ST_BUSY;
          sel_d       = gnt_id;
          last_d      = gnt_id;
          cnt_d       = CNT_INIT;
          we_d        = (gnt_id == CORE1) ? we1 : we0;
          mem_en_d    = 1'b1;
          mem_we_d    = (gnt_id == CORE1) ? we1 : we0;
          mem_addr_d  = (gnt_id == CORE1) ? addr1 : addr0;
          mem_wdata_d = (gnt_id == CORE1) ? wdata1 : wdata0;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Final latency cycle: mem_rdata is only trusted here.
          state_d  = ST_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (!we_q) begin
            if (sel_q == CORE1) rdata1_d = mem_rdata;
            else                rdata0_d = mem_rdata;
          end
          if (sel_q == CORE1) ack1_d = 1'b1;
          else                ack0_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= CORE1;
      sel_q       <= CORE0;
      we_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a MEM_LAT=1 and a MEM_LAT=4 instance checked against a transaction-timing model.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index i = 2*instance + core; instance 0 has MEM_LAT=1, instance 1 has MEM_LAT=4.
  logic        req_i   [4];
  logic        we_i    [4];
  logic [31:0] addr_i  [4];
  logic [31:0] wdata_i [4];
  logic        ack_o   [4];
  logic [31:0] rdata_o [4];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req_i[0]), .we0(we_i[0]), .addr0(addr_i[0]), .wdata0(wdata_i[0]),
    .req1(req_i[1]), .we1(we_i[1]), .addr1(addr_i[1]), .wdata1(wdata_i[1]),
    .ack0(ack_o[0]), .rdata0(rdata_o[0]), .ack1(ack_o[1]), .rdata1(rdata_o[1]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .req0(req_i[2]), .we0(we_i[2]), .addr0(addr_i[2]), .wdata0(wdata_i[2]),
    .req1(req_i[3]), .we1(we_i[3]), .addr1(addr_i[3]), .wdata1(wdata_i[3]),
    .ack0(ack_o[2]), .rdata0(rdata_o[2]), .ack1(ack_o[3]), .rdata1(rdata_o[3]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [32:0] mkey(input int k, input logic [31:0] a);
    logic [31:0] kk;
    kk = 32'(k);
    return {kk[0], a};
  endfunction

  // Reference memory (updated at grant) and bench memory (updated by the responder).
  logic [31:0] rmem [logic [32:0]];
  logic [31:0] dmem [logic [32:0]];

  function automatic logic [31:0] ref_get(input int k, input logic [31:0] a);
    if (rmem.exists(mkey(k, a))) return rmem[mkey(k, a)];
    return init_val(a);
  endfunction

  function automatic logic [31:0] dmem_get(input int k, input logic [31:0] a);
    if (dmem.exists(mkey(k, a))) return dmem[mkey(k, a)];
    return init_val(a);
  endfunction

  // Transaction-level model: an arbiter that is free again MEM_LAT+2 edges after a grant.
  int          e      [2];
  int          g_e    [2];
  int          free_e [2];
  bit          g_v    [2];
  logic        g_core [2];
  logic        g_we   [2];
  logic        last   [2];
  logic [31:0] g_addr [2];
  logic [31:0] g_wdata[2];
  logic [31:0] pend_rd[2];
  logic [31:0] exp_rd [4];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          e[k] = 0; free_e[k] = 0; g_e[k] = 0; g_v[k] = 1'b0; last[k] = 1'b1;
          exp_rd[2*k] = '0; exp_rd[2*k+1] = '0;
        end else begin
          logic c;
          int   idx;
          e[k]++;
          if (g_v[k] && e[k] == g_e[k] + lat(k) && !g_we[k])
            exp_rd[2*k + (g_core[k] ? 1 : 0)] = pend_rd[k];
          if (e[k] >= free_e[k] && (req_i[2*k] || req_i[2*k+1])) begin
            c   = (req_i[2*k] && req_i[2*k+1]) ? !last[k] : req_i[2*k+1];
            idx = 2*k + (c ? 1 : 0);
            g_v[k] = 1'b1; g_e[k] = e[k]; g_core[k] = c; last[k] = c;
            g_we[k] = we_i[idx]; g_addr[k] = addr_i[idx]; g_wdata[k] = wdata_i[idx];
            free_e[k] = e[k] + lat(k) + 2;
            if (!g_we[k]) pend_rd[k] = ref_get(k, g_addr[k]);
            else          rmem[mkey(k, g_addr[k])] = g_wdata[k];
          end
        end
      end
    end
  end

  int alog  [2][$];
  int aloge [2][$];
  int en_cnt[2];

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          int    d;
          bit    inb, ackc;
          string p;
          p    = $sformatf("L%0d", lat(k));
          d    = g_v[k] ? (e[k] - g_e[k]) : -1;
          inb  = (d >= 0) && (d < lat(k));
          ackc = (d == lat(k));
          check_eq({p, "_mem_en"}, 32'(mem_en[k]), 32'(inb));
          check_eq({p, "_busy"},   32'(busy[k]),   32'((d >= 0) && (d <= lat(k))));
          check_eq({p, "_ack0"},   32'(ack_o[2*k]),   32'(ackc && g_core[k] == 1'b0));
          check_eq({p, "_ack1"},   32'(ack_o[2*k+1]), 32'(ackc && g_core[k] == 1'b1));
          check_eq({p, "_rdata0"}, rdata_o[2*k],   exp_rd[2*k]);
          check_eq({p, "_rdata1"}, rdata_o[2*k+1], exp_rd[2*k+1]);
          if (inb) begin
            check_eq({p, "_mem_we"},   32'(mem_we[k]), 32'(g_we[k]));
            check_eq({p, "_mem_addr"}, mem_addr[k], g_addr[k]);
            if (g_we[k]) check_eq({p, "_mem_wdata"}, mem_wdata[k], g_wdata[k]);
          end
          if (mem_en[k]) en_cnt[k]++;
          if (ack_o[2*k])   begin alog[k].push_back(0); aloge[k].push_back(e[k]); end
          if (ack_o[2*k+1]) begin alog[k].push_back(1); aloge[k].push_back(e[k]); end
        end
      end
    end
  end

  // Memory responder: read data is garbage except in the last cycle of each latency window.
  int run[2];
  initial begin
    mem_rdata[0] = '0; mem_rdata[1] = '0; run[0] = 0; run[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        mem_rdata[k] = $urandom;
        if (!rst_n || !mem_en[k]) begin
          run[k] = 0;
        end else begin
          run[k]++;
          if (run[k] == lat(k)) begin
            if (mem_we[k]) dmem[mkey(k, mem_addr[k])] = mem_wdata[k];
            else           mem_rdata[k] = dmem_get(k, mem_addr[k]);
          end
        end
      end
    end
  end

  // Core drivers: hold a request until ack, scramble operands while it is in flight.
  op_t opq [4][$];
  initial begin
    for (int i = 0; i < 4; i++) begin
      req_i[i] = 1'b0; we_i[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        int   k;
        logic c;
        op_t  o;
        k = i / 2;
        c = (i % 2) == 1;
        if (!rst_n) begin
          req_i[i] = 1'b0;
          opq[i].delete();
        end else begin
          if (req_i[i] && ack_o[i]) begin
            req_i[i] = 1'b0;
          end else if (req_i[i] && g_v[k] && g_core[k] == c && (e[k] - g_e[k]) < lat(k)) begin
            addr_i[i]  = $urandom;
            wdata_i[i] = $urandom;
            we_i[i]    = 1'($urandom);
          end
          if (!req_i[i] && opq[i].size() > 0) begin
            if (opq[i][0].gap > 0) begin
              opq[i][0].gap = opq[i][0].gap - 1;
            end else begin
              o = opq[i].pop_front();
              req_i[i] = 1'b1; we_i[i] = o.we; addr_i[i] = o.addr; wdata_i[i] = o.wdata;
            end
          end
        end
      end
    end
  end

  task automatic push_op(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int gap);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d; o.gap = gap;
    opq[i].push_back(o);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      alog[k].delete(); aloge[k].delete(); en_cnt[k] = 0;
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_ack0"},      32'(ack_o[2*k]),   32'd0);
      check_eq({tag, "_ack1"},      32'(ack_o[2*k+1]), 32'd0);
      check_eq({tag, "_rdata0"},    rdata_o[2*k],      32'd0);
      check_eq({tag, "_rdata1"},    rdata_o[2*k+1],    32'd0);
      check_eq({tag, "_mem_en"},    32'(mem_en[k]),    32'd0);
      check_eq({tag, "_mem_we"},    32'(mem_we[k]),    32'd0);
      check_eq({tag, "_mem_addr"},  mem_addr[k],       32'd0);
      check_eq({tag, "_mem_wdata"}, mem_wdata[k],      32'd0);
      check_eq({tag, "_busy"},      32'(busy[k]),      32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    forever begin
      bit idle;
      @(negedge clk);
      #1;
      n++;
      idle = !busy[0] && !busy[1];
      for (int i = 0; i < 4; i++) if (req_i[i] || opq[i].size() > 0) idle = 1'b0;
      if (idle) break;
      if (n >= maxc) begin
        check_eq("idle_timeout", 32'(n), 32'(maxc + 1));
        break;
      end
    end
  endtask

  initial begin
    do_reset();

    // Single load of 0x40 on the MEM_LAT=1 instance.
    push_op(0, 1'b0, 32'h40, 32'h0, 0);
    wait_idle(50);
    check_eq("single_rdata0", rdata_o[0], 32'hDEADBEEF);
    check_eq("single_acks", 32'(alog[0].size()), 32'd1);
    check_eq("single_en_cycles", 32'(en_cnt[0]), 32'd1);

    // Simultaneous requests straight out of reset.
    do_reset();
    push_op(0, 1'b0, 32'h10, 32'h0, 0);
    push_op(1, 1'b1, 32'h20, 32'h55, 0);
    wait_idle(50);
    check_eq("simul_nacks", 32'(alog[0].size()), 32'd2);
    if (alog[0].size() == 2) begin
      check_eq("simul_first", 32'(alog[0][0]), 32'd0);
      check_eq("simul_second", 32'(alog[0][1]), 32'd1);
      check_eq("simul_spacing", 32'(aloge[0][1] - aloge[0][0]), 32'd3);
    end

    // Both cores hold requests back-to-back on both instances.
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) push_op(i, 1'b0, 32'(32'h200 + 4*j), 32'h0, 0);
    wait_idle(200);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rr_nacks_L%0d", lat(k)), 32'(alog[k].size()), 32'd6);
      if (alog[k].size() == 6)
        for (int j = 0; j < 6; j++)
          check_eq($sformatf("rr_order_L%0d_%0d", lat(k), j), 32'(alog[k][j]), 32'(j % 2));
    end

    // MEM_LAT=4 core1 load: four BUSY cycles, ack four edges after the grant edge.
    clear_logs();
    push_op(3, 1'b0, 32'h40, 32'h0, 0);
    wait_idle(50);
    check_eq("lat4_en_cycles", 32'(en_cnt[1]), 32'd4);
    check_eq("lat4_nacks", 32'(alog[1].size()), 32'd1);
    if (alog[1].size() == 1)
      check_eq("lat4_ack_edge", 32'(aloge[1][0] - g_e[1]), 32'd4);
    check_eq("lat4_rdata1", rdata_o[3], 32'hDEADBEEF);

    // Randomised traffic over a small shared address pool.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 60; j++)
        push_op(i, 1'($urandom), 32'(32'h100 + 4*$urandom_range(0, 7)), $urandom,
                int'($urandom_range(0, 3)));
    wait_idle(5000);

    // Reset in the second BUSY cycle of a MEM_LAT=4 load.
    clear_logs();
    push_op(3, 1'b0, 32'h104, 32'h0, 0);
    begin
      int n;
      n = 0;
      while (!(g_v[1] && (e[1] - g_e[1]) == 1) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("midrst_reach", 32'(n < 50), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("midrst_hold_ack1", 32'(ack_o[3]), 32'd0);
      check_eq("midrst_hold_en", 32'(mem_en[1]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_no_ack", 32'(alog[1].size()), 32'd0);
    clear_logs();
    push_op(2, 1'b0, 32'h108, 32'h0, 0);
    push_op(3, 1'b0, 32'h10C, 32'h0, 0);
    wait_idle(100);
    check_eq("post_rst_nacks", 32'(alog[1].size()), 32'd2);
    if (alog[1].size() == 2) check_eq("post_rst_tie", 32'(alog[1][0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
